// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller and forwarding unit.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned REG_ZERO    = 0;
  localparam int unsigned DRAIN_CNT_W = 4;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_bubble;
  } pipe_ctrl_t;

  // All five load enables driven to en, no flush and no bubble.
  function automatic pipe_ctrl_t ctrl_all(input logic en);
    pipe_ctrl_t c;
    c.pc_en       = en;
    c.ifid_en     = en;
    c.idex_en     = en;
    c.exmem_en    = en;
    c.memwb_en    = en;
    c.ifid_flush  = 1'b0;
    c.idex_bubble = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Stage-side signals seen by the hazard controller and the controls it returns.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned ADDR_LEFT = 4,
  parameter int unsigned CNT_BITS  = 16
);
  logic [ADDR_LEFT:0]  rs_addr;
  logic [ADDR_LEFT:0]  rt_addr;
  logic                rs_used;
  logic                rt_used;
  logic [ADDR_LEFT:0]  waddr_s3;
  logic                rw_s3;
  logic                sel_mem_s3;
  logic                jump_taken_s3;
  logic                halt_s2;
  logic                mem_req_s4;
  logic                mem_ready;
  logic                clr_stats;
  logic                pc_en;
  logic                ifid_en;
  logic                idex_en;
  logic                exmem_en;
  logic                memwb_en;
  logic                ifid_flush;
  logic                idex_bubble;
  logic                halted;
  logic [CNT_BITS-1:0] stall_cycles;

  modport master (
    output rs_addr, rt_addr, rs_used, rt_used, waddr_s3, rw_s3, sel_mem_s3,
           jump_taken_s3, halt_s2, mem_req_s4, mem_ready, clr_stats,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush,
           idex_bubble, halted, stall_cycles
  );

  modport slave (
    input  rs_addr, rt_addr, rs_used, rt_used, waddr_s3, rw_s3, sel_mem_s3,
           jump_taken_s3, halt_s2, mem_req_s4, mem_ready, clr_stats,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush,
           idex_bubble, halted, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX writes a register the ID instruction reads.
module pipe_hazard_ctrl_hazard_detect
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_LEFT = 4
) (
  input  logic [ADDR_LEFT:0] rs_addr,
  input  logic [ADDR_LEFT:0] rt_addr,
  input  logic               rs_used,
  input  logic               rt_used,
  input  logic [ADDR_LEFT:0] waddr_s3,
  input  logic               rw_s3,
  input  logic               sel_mem_s3,
  output logic               load_use_c
);

  localparam int unsigned ADDR_W = ADDR_LEFT + 1;

  logic dest_live;
  logic rs_hit;
  logic rt_hit;

  // rw_s3 is active-low; register zero is hard-wired and never a real producer.
  assign dest_live  = sel_mem_s3 & ~rw_s3 & (waddr_s3 != ADDR_W'(REG_ZERO));
  assign rs_hit     = rs_used & (rs_addr == waddr_s3);
  assign rt_hit     = rt_used & (rt_addr == waddr_s3);
  assign load_use_c = dest_live & (rs_hit | rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/sequencing controller: stall, flush, bubble, halt drain
// and a saturating stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_WORDS    = 32,
  parameter int unsigned ADDR_LEFT    = $clog2(REG_WORDS) - 1,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_BITS     = 16
) (
  input logic               clk,
  input logic               rst_,
  pipe_hazard_ctrl_if.slave bus
);

  logic [1:0]             state;
  logic [1:0]             state_nxt;
  logic [DRAIN_CNT_W-1:0] drain_cnt;
  logic [DRAIN_CNT_W-1:0] drain_cnt_nxt;
  logic [CNT_BITS-1:0]    stall_q;
  logic [CNT_BITS-1:0]    stall_nxt;
  logic                   stall_inc;
  logic                   halted_c;
  logic                   freeze_c;
  logic                   load_use_c;
  pipe_ctrl_t             ctrl;

  pipe_hazard_ctrl_hazard_detect #(
    .ADDR_LEFT (ADDR_LEFT)
  ) u_hazard_detect (
    .rs_addr    (bus.rs_addr),
    .rt_addr    (bus.rt_addr),
    .rs_used    (bus.rs_used),
    .rt_used    (bus.rt_used),
    .waddr_s3   (bus.waddr_s3),
    .rw_s3      (bus.rw_s3),
    .sel_mem_s3 (bus.sel_mem_s3),
    .load_use_c (load_use_c)
  );

  assign freeze_c = bus.mem_req_s4 & ~bus.mem_ready;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
      stall_q   <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
      stall_q   <= stall_nxt;
    end
  end

  // Priority in RUN: freeze > redirect > load_use > halt.
  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    ctrl          = ctrl_all(1'b0);
    halted_c      = 1'b0;
    stall_inc     = 1'b0;

    case (state)
      ST_RUN: begin
        stall_inc = freeze_c | load_use_c;
        if (freeze_c) begin
          ctrl = ctrl_all(1'b0);
        end else if (bus.jump_taken_s3) begin
          ctrl             = ctrl_all(1'b1);
          ctrl.ifid_flush  = 1'b1;
          ctrl.idex_bubble = 1'b1;
        end else if (load_use_c) begin
          ctrl             = ctrl_all(1'b1);
          ctrl.pc_en       = 1'b0;
          ctrl.ifid_en     = 1'b0;
          ctrl.idex_bubble = 1'b1;
        end else if (bus.halt_s2) begin
          ctrl          = ctrl_all(1'b1);
          state_nxt     = ST_DRAIN;
          drain_cnt_nxt = DRAIN_CNT_W'(DRAIN_CYCLES);
        end else begin
          ctrl = ctrl_all(1'b1);
        end
      end

      ST_DRAIN: begin
        stall_inc = freeze_c | load_use_c;
        if (!freeze_c) begin
          // Only bubbles enter EX from here on, so redirects cannot occur.
          ctrl             = ctrl_all(1'b1);
          ctrl.pc_en       = 1'b0;
          ctrl.ifid_en     = 1'b0;
          ctrl.idex_bubble = 1'b1;
          drain_cnt_nxt    = drain_cnt - DRAIN_CNT_W'(1);
          if (drain_cnt == DRAIN_CNT_W'(1)) begin
            state_nxt = ST_HALTED;
          end
        end
      end

      ST_HALTED: begin
        halted_c = 1'b1;
      end

      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  // Saturating stall counter; clear wins over increment.
  always_comb begin
    stall_nxt = stall_q;
    if (bus.clr_stats) begin
      stall_nxt = '0;
    end else if (stall_inc && (stall_q != {CNT_BITS{1'b1}})) begin
      stall_nxt = stall_q + CNT_BITS'(1);
    end
  end

  // Controls are forced inactive for as long as reset is held.
  assign bus.pc_en        = rst_ & ctrl.pc_en;
  assign bus.ifid_en      = rst_ & ctrl.ifid_en;
  assign bus.idex_en      = rst_ & ctrl.idex_en;
  assign bus.exmem_en     = rst_ & ctrl.exmem_en;
  assign bus.memwb_en     = rst_ & ctrl.memwb_en;
  assign bus.ifid_flush   = rst_ & ctrl.ifid_flush;
  assign bus.idex_bubble  = rst_ & ctrl.idex_bubble;
  assign bus.halted       = rst_ & halted_c;
  assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed test-plan cases then random traffic.
module tb_pipe_hazard_ctrl;

  localparam int unsigned DRAIN   = 3;
  localparam int unsigned CNTB    = 5;
  localparam int          CNT_MAX = 31;

  typedef struct {
    logic       rst_;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rs_used;
    logic       rt_used;
    logic [4:0] waddr;
    logic       rw;
    logic       sel_mem;
    logic       jump;
    logic       halt;
    logic       mem_req;
    logic       mem_ready;
    logic       clr;
  } stim_t;

  typedef struct packed {
    logic [7:0]      ctl;   // pc, ifid, idex, exmem, memwb, flush, bubble, halted
    logic [CNTB-1:0] stall;
  } exp_t;

  logic clk;
  logic rst_;
  exp_t exp_q[$];
  int   checks;
  int   fails;
  int   step_no;

  // Reference model state: pipeline mode as plain flags and a cycles-left count.
  bit   draining;
  bit   stopped;
  int   cycles_left;
  int   stall_count;

  pipe_hazard_ctrl_if #(.ADDR_LEFT(4), .CNT_BITS(CNTB)) bus ();

  pipe_hazard_ctrl #(
    .REG_WORDS    (32),
    .ADDR_LEFT    (4),
    .DRAIN_CYCLES (DRAIN),
    .CNT_BITS     (CNTB)
  ) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t idle();
    stim_t s;
    s.rst_ = 1'b1; s.rs = '0; s.rt = '0; s.rs_used = 1'b0; s.rt_used = 1'b0;
    s.waddr = '0; s.rw = 1'b1; s.sel_mem = 1'b0; s.jump = 1'b0; s.halt = 1'b0;
    s.mem_req = 1'b0; s.mem_ready = 1'b1; s.clr = 1'b0;
    return s;
  endfunction

  function automatic stim_t load_hit(input logic [4:0] r);
    stim_t s;
    s = idle();
    s.sel_mem = 1'b1; s.rw = 1'b0; s.waddr = r; s.rs = r; s.rs_used = 1'b1;
    return s;
  endfunction

  // Drive one cycle of inputs, queue the expected response and advance the model.
  task automatic step(input stim_t s);
    exp_t e;
    bit   fz;
    bit   lu;
    bit   pc, ifid, idex, exmem, memwb, flush, bubble, hlt;
    @(negedge clk);
    rst_              = s.rst_;
    bus.rs_addr       = s.rs;
    bus.rt_addr       = s.rt;
    bus.rs_used       = s.rs_used;
    bus.rt_used       = s.rt_used;
    bus.waddr_s3      = s.waddr;
    bus.rw_s3         = s.rw;
    bus.sel_mem_s3    = s.sel_mem;
    bus.jump_taken_s3 = s.jump;
    bus.halt_s2       = s.halt;
    bus.mem_req_s4    = s.mem_req;
    bus.mem_ready     = s.mem_ready;
    bus.clr_stats     = s.clr;

    fz = s.mem_req && !s.mem_ready;
    lu = s.sel_mem && !s.rw && (s.waddr != 0) &&
         ((s.rs_used && s.rs == s.waddr) || (s.rt_used && s.rt == s.waddr));
    {pc, ifid, idex, exmem, memwb, flush, bubble, hlt} = '0;

    if (!s.rst_) begin
      draining = 0; stopped = 0; cycles_left = 0; stall_count = 0;
      e.ctl   = '0;
      e.stall = '0;
    end else begin
      e.stall = CNTB'(stall_count);
      if (stopped) hlt = 1;
      else if (fz) ;
      else if (draining) begin
        {idex, exmem, memwb, bubble} = 4'b1111;
      end else if (s.jump) begin
        {pc, ifid, idex, exmem, memwb, flush, bubble} = 7'b1111111;
      end else if (lu) begin
        {idex, exmem, memwb, bubble} = 4'b1111;
      end else begin
        {pc, ifid, idex, exmem, memwb} = 5'b11111;
      end
      e.ctl = {pc, ifid, idex, exmem, memwb, flush, bubble, hlt};

      if (s.clr) stall_count = 0;
      else if (!stopped && (fz || lu) && stall_count < CNT_MAX) stall_count++;

      if (!stopped && !fz) begin
        if (draining) begin
          cycles_left--;
          if (cycles_left == 0) begin draining = 0; stopped = 1; end
        end else if (!s.jump && !lu && s.halt) begin
          draining = 1; cycles_left = DRAIN;
        end
      end
    end
    exp_q.push_back(e);
    step_no++;
  endtask

  // Monitor: outputs are valid every cycle; pop and compare mid-low-phase.
  initial begin
    exp_t e;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
               bus.ifid_flush, bus.idex_bubble, bus.halted};
        checks++;
        if (act !== e.ctl) begin
          fails++;
          $display("FAIL ctrl @step %0d: got %b required %b (pc,ifid,idex,exmem,memwb,flush,bubble,halted)",
                   step_no, act, e.ctl);
        end
        checks++;
        if (bus.stall_cycles !== e.stall) begin
          fails++;
          $display("FAIL stall_cycles @step %0d: got %0d required %0d", step_no, bus.stall_cycles, e.stall);
        end
      end
    end
  end

  initial begin
    stim_t s;
    checks = 0; fails = 0; step_no = 0;
    draining = 0; stopped = 0; cycles_left = 0; stall_count = 0;
    s = idle();
    rst_ = 1'b0;
    bus.rs_addr = '0; bus.rt_addr = '0; bus.rs_used = 0; bus.rt_used = 0;
    bus.waddr_s3 = '0; bus.rw_s3 = 1; bus.sel_mem_s3 = 0; bus.jump_taken_s3 = 0;
    bus.halt_s2 = 0; bus.mem_req_s4 = 0; bus.mem_ready = 1; bus.clr_stats = 0;

    s.rst_ = 1'b0; step(s); step(s);
    step(idle());

    // Load-use on rs, then register zero never stalls.
    step(load_hit(5'd5)); step(idle());
    step(load_hit(5'd0)); step(idle());
    s = load_hit(5'd7); s.rs_used = 0; s.rt = 5'd7; s.rt_used = 1; step(s);

    // Redirect beats load-use and halt.
    s = load_hit(5'd5); s.jump = 1; s.halt = 1; step(s); step(idle());

    // Memory freeze over a load-use: 3 frozen cycles then one bubble.
    s = idle(); s.clr = 1; step(s);
    s = load_hit(5'd9); s.mem_req = 1; s.mem_ready = 0;
    repeat (3) step(s);
    step(load_hit(5'd9)); step(idle()); step(idle());

    // Halt drain with one freeze cycle inside the drain.
    s = idle(); s.halt = 1; step(s);
    step(idle());
    s = idle(); s.mem_req = 1; s.mem_ready = 0; step(s);
    repeat (5) step(idle());

    // Reset recovers from HALTED; second halt aborted by reset mid-drain.
    s = idle(); s.rst_ = 0; step(s);
    s = idle(); s.halt = 1; step(s);
    step(idle());
    s = idle(); s.rst_ = 0; step(s);
    repeat (5) step(idle());

    // Saturation of the small stall counter, then clear wins over a stall.
    s = idle(); s.mem_req = 1; s.mem_ready = 0;
    repeat (CNT_MAX + 4) step(s);
    step(load_hit(5'd3));
    s = load_hit(5'd3); s.clr = 1; step(s);
    step(idle());

    // Random traffic with narrow register addresses to provoke hits.
    for (int i = 0; i < 3000; i++) begin
      s.rst_      = ($urandom_range(0, 39) != 0);
      s.rs        = 5'($urandom_range(0, 3));
      s.rt        = 5'($urandom_range(0, 3));
      s.rs_used   = 1'($urandom);
      s.rt_used   = 1'($urandom);
      s.waddr     = 5'($urandom_range(0, 3));
      s.rw        = 1'($urandom);
      s.sel_mem   = 1'($urandom);
      s.jump      = ($urandom_range(0, 5) == 0);
      s.halt      = ($urandom_range(0, 15) == 0);
      s.mem_req   = ($urandom_range(0, 2) == 0);
      s.mem_ready = 1'($urandom);
      s.clr       = ($urandom_range(0, 49) == 0);
      step(s);
    end

    repeat (3) @(negedge clk);
    #4;
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard drain: got %0d pending required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
